// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_type (package)
// Description : Shared types and constants for the RV32I fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_type;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    localparam rv32i_word c_pc_reset = 32'h4000_0060;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small FIFO of {pc, instruction} pairs between fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv32i_type::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_depth = DEPTH[c_aw:0];

    fetch_entry_t    r_mem [DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign count  = r_wr_ptr - r_rd_ptr;
    assign empty  = (count == '0);
    assign w_full = (count == c_depth);
    assign w_push = push & ~w_full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch: PC, single-outstanding icache reads,
//               redirect handling with stale-response discard, decode FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import rv32i_type::*;
#(
    parameter logic [31:0] PC_RESET = c_pc_reset,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = DEPTH[c_aw:0];

    fetch_state_t   r_state;
    fetch_state_t   w_state_next;
    rv32i_word      r_pc;
    rv32i_word      w_pc_next;
    rv32i_word      r_pc_req;
    rv32i_word      w_pc_aligned;
    logic           r_busy;
    logic           w_busy_next;

    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;
    logic           w_empty;
    logic [c_aw:0]  w_count;
    logic [c_aw:0]  w_count_after;
    logic           w_push;
    logic           w_pop;
    logic           w_flush;

    assign w_pc_aligned  = r_pc & ~32'd3;
    assign imem_addr     = r_busy ? r_pc_req : w_pc_aligned;
    assign valid_o       = ~w_empty;
    assign w_pop         = valid_o & ready_i;
    // Occupancy without a push: a push needs an outstanding request, which
    // already keeps imem_read high on its own.
    assign w_count_after = w_count - {{c_aw{1'b0}}, w_pop};
    assign w_push_entry  = '{pc: imem_addr, instr: imem_rdata};
    assign pc_o          = w_head.pc;
    assign instruction_o = w_head.instr;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        // A redirect with nothing outstanding suppresses the issue so the
        // next request goes out at the redirected PC.
        imem_read    = rst & (r_busy | ((r_state == FETCH) & ~redirect_i &
                                        (w_count_after < c_depth)));
        w_busy_next  = imem_read & ~imem_resp;

        unique case (r_state)
            FETCH: begin
                if (redirect_i) begin
                    w_flush   = 1'b1;
                    w_pc_next = redirect_pc_i;
                    if (r_busy & ~imem_resp) begin
                        w_state_next = DISCARD;
                    end
                end else if (imem_read & imem_resp) begin
                    w_push    = 1'b1;
                    w_pc_next = imem_addr + 32'd4;
                end
            end
            DISCARD: begin
                if (redirect_i) begin
                    w_flush   = 1'b1;
                    w_pc_next = redirect_pc_i;
                end
                if (imem_resp) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= FETCH;
            r_pc     <= PC_RESET;
            r_pc_req <= PC_RESET;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_busy  <= w_busy_next;
            if (imem_read & ~r_busy) begin
                r_pc_req <= w_pc_aligned;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed scoreboard bench for fetch_stage with a cache model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import rv32i_type::*;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t exp_out  [$];
    logic [31:0]  exp_addr [$];
    int           lat_q    [$];

    fetch_stage #(
        .PC_RESET (32'h4000_0060),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [31:0] p, input logic [31:0] i);
        exp_out.push_back('{pc: p, instr: i});
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        ready_i    = 1'b0;
        redirect_i = 1'b0;
        repeat (3) step();
        exp_out.delete();
        exp_addr.delete();
        lat_q.delete();
    endtask

    task automatic release_rst();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_out.size() != 0; i++) step();
        check("drain_remaining", 32'(exp_out.size()), 32'd0);
    endtask

    // Cache model: latency per request from lat_q (default 1), data = ~addr.
    initial begin : cache_model
        bit          c_wait;
        int          c_cnt;
        int          c_lat;
        logic [31:0] c_addr;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        c_wait     = 1'b0;
        c_cnt      = 0;
        c_lat      = 1;
        c_addr     = '0;
        forever begin
            @(negedge clk);
            imem_resp = 1'b0;
            if (!rst) begin
                c_wait = 1'b0;
            end else if (imem_read) begin
                if (!c_wait) begin
                    c_wait = 1'b1;
                    c_cnt  = 0;
                    c_addr = imem_addr;
                    c_lat  = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
                    if (exp_addr.size() != 0) check("req_addr", imem_addr, exp_addr.pop_front());
                end else begin
                    check("req_addr_stable", imem_addr, c_addr);
                end
                if (c_cnt == c_lat) begin
                    imem_resp  = 1'b1;
                    imem_rdata = ~c_addr;
                    c_wait     = 1'b0;
                end else begin
                    c_cnt++;
                end
            end
        end
    end

    // Decode-side monitor: every transfer must match the scoreboard head.
    initial begin : decode_monitor
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst && valid_o && ready_i) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL decode_unexpected: got pc %h instr %h, expected no transfer",
                             pc_o, instruction_o);
                end else begin
                    e = exp_out.pop_front();
                    check("decode_pc", pc_o, e.pc);
                    check("decode_instr", instruction_o, e.instr);
                end
            end
        end
    end

    initial begin : stimulus
        rst           = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) step();
        @(negedge clk);
        check("rst_read", {31'd0, imem_read}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_addr", imem_addr, 32'h4000_0060);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_instr", instruction_o, 32'h0);

        // Streaming with ready high
        exp_addr = '{32'h4000_0060, 32'h4000_0064, 32'h4000_0068};
        push_out(32'h4000_0060, 32'hBFFF_FF9F);
        push_out(32'h4000_0064, 32'hBFFF_FF9B);
        push_out(32'h4000_0068, 32'hBFFF_FF97);
        ready_i = 1'b1;
        release_rst();
        @(negedge clk);
        check("first_read", {31'd0, imem_read}, 32'd1);
        check("first_addr", imem_addr, 32'h4000_0060);
        check("first_valid_c0", {31'd0, valid_o}, 32'd0);
        step();
        @(negedge clk);
        check("first_valid_c1", {31'd0, valid_o}, 32'd0);
        step();
        @(negedge clk);
        check("first_valid_c2", {31'd0, valid_o}, 32'd1);
        wait_drain();
        ready_i = 1'b0;

        // Backpressure fills the FIFO, then drains in order
        do_reset();
        exp_addr = '{32'h4000_0060, 32'h4000_0064, 32'h4000_0068};
        push_out(32'h4000_0060, 32'hBFFF_FF9F);
        push_out(32'h4000_0064, 32'hBFFF_FF9B);
        push_out(32'h4000_0068, 32'hBFFF_FF97);
        release_rst();
        repeat (4) step();
        @(negedge clk);
        check("full_read_c4", {31'd0, imem_read}, 32'd0);
        check("full_head_c4", pc_o, 32'h4000_0060);
        repeat (5) step();
        @(negedge clk);
        check("full_read_c9", {31'd0, imem_read}, 32'd0);
        check("full_valid_c9", {31'd0, valid_o}, 32'd1);
        check("full_head_c9", pc_o, 32'h4000_0060);
        check("full_instr_c9", instruction_o, 32'hBFFF_FF9F);
        step();
        ready_i = 1'b1;
        wait_drain();
        ready_i = 1'b0;

        // Redirect while a slow request is outstanding
        do_reset();
        ready_i  = 1'b1;
        lat_q    = '{1, 1, 3};
        exp_addr = '{32'h4000_0060, 32'h4000_0064, 32'h4000_0068, 32'h4000_0100, 32'h4000_0104};
        push_out(32'h4000_0060, 32'hBFFF_FF9F);
        push_out(32'h4000_0064, 32'hBFFF_FF9B);
        push_out(32'h4000_0100, 32'hBFFF_FEFF);
        release_rst();
        repeat (5) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000_0100;
        @(negedge clk);
        check("disc_read_c5", {31'd0, imem_read}, 32'd1);
        check("disc_addr_c5", imem_addr, 32'h4000_0068);
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("disc_addr_c6", imem_addr, 32'h4000_0068);
        step();
        @(negedge clk);
        check("disc_addr_c7", imem_addr, 32'h4000_0068);
        step();
        @(negedge clk);
        check("disc_new_addr", imem_addr, 32'h4000_0100);
        check("disc_new_read", {31'd0, imem_read}, 32'd1);
        check("disc_valid", {31'd0, valid_o}, 32'd0);
        wait_drain();
        ready_i = 1'b0;

        // Redirect coincident with a response, old head popped in same cycle
        do_reset();
        exp_addr = '{32'h4000_0060, 32'h4000_0064, 32'h4000_0200, 32'h4000_0204};
        push_out(32'h4000_0060, 32'hBFFF_FF9F);
        push_out(32'h4000_0200, 32'hBFFF_FDFF);
        release_rst();
        repeat (3) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000_0200;
        ready_i       = 1'b1;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("coin_valid", {31'd0, valid_o}, 32'd0);
        check("coin_read", {31'd0, imem_read}, 32'd1);
        check("coin_addr", imem_addr, 32'h4000_0200);
        wait_drain();
        ready_i = 1'b0;

        // Redirect near the top of the address space wraps to zero
        do_reset();
        ready_i  = 1'b1;
        exp_addr = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        push_out(32'hFFFF_FFFC, 32'h0000_0003);
        push_out(32'h0000_0000, 32'hFFFF_FFFF);
        step();
        rst           = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("wrap_read", {31'd0, imem_read}, 32'd1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_valid", {31'd0, valid_o}, 32'd0);
        wait_drain();
        ready_i = 1'b0;

        // Reset while waiting on a response with a buffered entry
        do_reset();
        lat_q    = '{1, 6};
        exp_addr = '{32'h4000_0060, 32'h4000_0064};
        release_rst();
        repeat (2) step();
        @(negedge clk);
        check("mid_pre_valid", {31'd0, valid_o}, 32'd1);
        check("mid_pre_pc", pc_o, 32'h4000_0060);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_read", {31'd0, imem_read}, 32'd0);
        step();
        @(negedge clk);
        check("mid_valid", {31'd0, valid_o}, 32'd0);
        check("mid_read", {31'd0, imem_read}, 32'd0);
        check("mid_addr", imem_addr, 32'h4000_0060);
        check("mid_pc_o", pc_o, 32'h0);
        check("mid_instr", instruction_o, 32'h0);

        // Reset while discarding a stale response
        exp_addr.delete();
        lat_q.delete();
        lat_q    = '{6};
        exp_addr = '{32'h4000_0060};
        ready_i  = 1'b1;
        release_rst();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000_0300;
        step();
        redirect_i = 1'b0;
        rst        = 1'b0;
        step();
        @(negedge clk);
        check("dsc_rst_valid", {31'd0, valid_o}, 32'd0);
        check("dsc_rst_read", {31'd0, imem_read}, 32'd0);
        check("dsc_rst_addr", imem_addr, 32'h4000_0060);

        exp_addr.delete();
        lat_q.delete();
        exp_addr = '{32'h4000_0060};
        push_out(32'h4000_0060, 32'hBFFF_FF9F);
        release_rst();
        @(negedge clk);
        check("post_rst_read", {31'd0, imem_read}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h4000_0060);
        wait_drain();
        ready_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
